// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes,
// datapath mux selects and ALUOp classes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;

  // Immediate format selected purely by opcode.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_LOAD, OP_ITYPE: imm = 2'b00;
      OP_STORE:          imm = 2'b01;
      OP_BRANCH:         imm = 2'b10;
      OP_JAL:            imm = 2'b11;
      default:           imm = 2'b00;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps ALUOp class plus funct fields to the ALU operation code.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  // Subtract only for R-type funct7[5]=1; immediate forms always add.
  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALUC_ADD;
      ALUOP_SUB: alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (op5 && funct7_5) begin
              alu_control = ALUC_SUB;
            end else begin
              alu_control = ALUC_ADD;
            end
          end
          3'b110:  alu_control = ALUC_OR;
          3'b111:  alu_control = ALUC_AND;
          default: alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main control FSM (lw, sw, R/I ALU ops, beq/bne, jal).
// Write enables are forced low whenever rst_n is asserted.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr
);

  state_t     state_r;
  state_t     next_state_s;
  logic [1:0] alu_op_s;
  logic       pc_write_s;
  logic       ir_write_s;
  logic       mem_write_s;
  logic       reg_write_s;
  logic       illegal_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE:          next_state_s = S_EXECR;
          OP_ITYPE:          next_state_s = S_EXECI;
          OP_BRANCH:         next_state_s = S_BRANCH;
          OP_JAL:            next_state_s = S_JAL;
          default:           next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LOAD) begin
          next_state_s = S_MEMREAD;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        if (mem_ready) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMREAD;
        end
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_EXECR, S_EXECI, S_JAL: next_state_s = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: next_state_s = S_FETCH;
      default: next_state_s = S_FETCH;
    endcase
  end

  // Per-state datapath controls; anything a state does not set stays zero.
  always_comb begin
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    alu_op_s    = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: illegal_s = 1'b0;
          default: illegal_s = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_op_s  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op_s  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RD1;
        alu_op_s  = ALUOP_SUB;
        case (funct3)
          3'b000:  pc_write_s = zero;
          3'b001:  pc_write_s = ~zero;
          default: pc_write_s = 1'b0;
        endcase
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b0;
      end
    endcase
  end

  assign pc_write      = pc_write_s & rst_n;
  assign ir_write      = ir_write_s & rst_n;
  assign mem_write     = mem_write_s & rst_n;
  assign reg_write     = reg_write_s & rst_n;
  assign illegal_instr = illegal_s & rst_n;
  assign imm_src       = imm_src_of(op);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op_s),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7_5    (funct7_5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: walks each instruction class through the FSM and checks the
// full control-output vector every cycle against hand-derived expectations.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_write, reg_write, adr_src, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [16:0] obs;
  int total;
  int bad;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .adr_src(adr_src),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal_instr(illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {pc_write, ir_write, mem_write, reg_write, adr_src, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};

  function automatic logic [16:0] ev(input logic pw, input logic iw, input logic mw,
      input logic rw, input logic adr, input logic [1:0] res, input logic [1:0] a,
      input logic [1:0] b, input logic [1:0] imm, input logic [2:0] aluc, input logic ill);
    return {pw, iw, mw, rw, adr, res, a, b, imm, aluc, ill};
  endfunction

  // Expected output vector per state, straight from the state table.
  function automatic logic [16:0] v_fetch(input logic mr, input logic [1:0] imm);
    return ev(mr, mr, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0);
  endfunction
  function automatic logic [16:0] v_decode(input logic [1:0] imm, input logic ill);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, ill);
  endfunction
  function automatic logic [16:0] v_memadr(input logic [1:0] imm);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 1'b0);
  endfunction
  function automatic logic [16:0] v_memread(input logic [1:0] imm);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0);
  endfunction
  function automatic logic [16:0] v_memwb(input logic [1:0] imm);
    return ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, imm, 3'b000, 1'b0);
  endfunction
  function automatic logic [16:0] v_memwrite(input logic [1:0] imm);
    return ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0);
  endfunction
  function automatic logic [16:0] v_exec(input logic is_r, input logic [1:0] imm,
                                         input logic [2:0] aluc);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, is_r ? 2'b00 : 2'b01,
              imm, aluc, 1'b0);
  endfunction
  function automatic logic [16:0] v_aluwb(input logic [1:0] imm);
    return ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0);
  endfunction
  function automatic logic [16:0] v_branch(input logic pw);
    return ev(pw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0);
  endfunction
  function automatic logic [16:0] v_jal();
    return ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [16:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic is_r, input logic [2:0] aluc);
    op = o; funct3 = f3; funct7_5 = f7; mem_ready = 1'b1;
    #1; chk({tag, "_fetch"}, v_fetch(1'b1, 2'b00));
    step(); chk({tag, "_decode"}, v_decode(2'b00, 1'b0));
    step(); chk({tag, "_exec"}, v_exec(is_r, 2'b00, aluc));
    step(); chk({tag, "_aluwb"}, v_aluwb(2'b00));
    step(); chk({tag, "_done"}, v_fetch(1'b1, 2'b00));
  endtask

  task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                            input logic pw);
    op = 7'b1100011; funct3 = f3; funct7_5 = 1'b0; zero = z; mem_ready = 1'b1;
    #1; chk({tag, "_fetch"}, v_fetch(1'b1, 2'b10));
    step(); chk({tag, "_decode"}, v_decode(2'b10, 1'b0));
    step(); chk({tag, "_branch"}, v_branch(pw));
    step(); chk({tag, "_done"}, v_fetch(1'b1, 2'b10));
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;

    // Reset: enables low regardless of mem_ready.
    #1; chk("rst_mr1", v_fetch(1'b0, 2'b00));
    mem_ready = 1'b0;
    #1; chk("rst_mr0", v_fetch(1'b0, 2'b00));
    mem_ready = 1'b1;
    step(); chk("rst_edge", v_fetch(1'b0, 2'b00));
    rst_n = 1'b1;

    // lw with mem_ready always 1: five cycles, reg_write only in the fifth.
    #1; chk("lw_fetch", v_fetch(1'b1, 2'b00));
    step(); chk("lw_decode", v_decode(2'b00, 1'b0));
    step(); chk("lw_memadr", v_memadr(2'b00));
    step(); chk("lw_memread", v_memread(2'b00));
    step(); chk("lw_memwb", v_memwb(2'b00));
    step(); chk("lw_done", v_fetch(1'b1, 2'b00));

    // sw with three wait cycles in MEMWRITE.
    op = 7'b0100011;
    #1; chk("sw_fetch", v_fetch(1'b1, 2'b01));
    step(); chk("sw_decode", v_decode(2'b01, 1'b0));
    step(); chk("sw_memadr", v_memadr(2'b01));
    mem_ready = 1'b0;
    step(); chk("sw_wait1", v_memwrite(2'b01));
    step(); chk("sw_wait2", v_memwrite(2'b01));
    step(); chk("sw_wait3", v_memwrite(2'b01));
    mem_ready = 1'b1;
    #1; chk("sw_last", v_memwrite(2'b01));
    step(); chk("sw_done", v_fetch(1'b1, 2'b01));

    // ALU instruction decode cases.
    run_alu("r_sub", 7'b0110011, 3'b000, 1'b1, 1'b1, 3'b001);
    run_alu("r_add", 7'b0110011, 3'b000, 1'b0, 1'b1, 3'b000);
    run_alu("r_or", 7'b0110011, 3'b110, 1'b0, 1'b1, 3'b011);
    run_alu("r_slt", 7'b0110011, 3'b010, 1'b1, 1'b1, 3'b000);
    run_alu("i_addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000);
    run_alu("i_andi", 7'b0010011, 3'b111, 1'b0, 1'b0, 3'b010);

    // Branches.
    run_branch("beq_z1", 3'b000, 1'b1, 1'b1);
    run_branch("beq_z0", 3'b000, 1'b0, 1'b0);
    run_branch("bne_z1", 3'b001, 1'b1, 1'b0);
    run_branch("bne_z0", 3'b001, 1'b0, 1'b1);
    run_branch("blt_z1", 3'b100, 1'b1, 1'b0);
    zero = 1'b0;

    // jal.
    op = 7'b1101111; funct3 = 3'b000;
    #1; chk("jal_fetch", v_fetch(1'b1, 2'b11));
    step(); chk("jal_decode", v_decode(2'b11, 1'b0));
    step(); chk("jal_jal", v_jal());
    step(); chk("jal_aluwb", v_aluwb(2'b11));
    step(); chk("jal_done", v_fetch(1'b1, 2'b11));

    // Unsupported opcode.
    op = 7'b1111111;
    #1; chk("ill_fetch", v_fetch(1'b1, 2'b00));
    step(); chk("ill_decode", v_decode(2'b00, 1'b1));
    step(); chk("ill_done", v_fetch(1'b1, 2'b00));

    // FETCH holds while memory is not ready.
    op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b0;
    #1; chk("fetch_wait1", v_fetch(1'b0, 2'b00));
    step(); chk("fetch_wait2", v_fetch(1'b0, 2'b00));
    mem_ready = 1'b1;
    #1; chk("fetch_go", v_fetch(1'b1, 2'b00));

    // Reset pulse during MEMREAD.
    step(); chk("rlw_decode", v_decode(2'b00, 1'b0));
    step(); chk("rlw_memadr", v_memadr(2'b00));
    mem_ready = 1'b0;
    step(); chk("rlw_memread", v_memread(2'b00));
    step(); chk("rlw_memread_hold", v_memread(2'b00));
    #2; rst_n = 1'b0; mem_ready = 1'b1;
    #1; chk("rlw_rst_async", v_fetch(1'b0, 2'b00));
    step(); chk("rlw_rst_edge", v_fetch(1'b0, 2'b00));
    #2; rst_n = 1'b1;
    #1; chk("rlw_resume_fetch", v_fetch(1'b1, 2'b00));
    step(); chk("rlw_resume_decode", v_decode(2'b00, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
